banked_dmem: RTL and testbench
==============================

BANKED_DMEM -- requirements
Module: banked_dmem

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 4, giving the byte lanes per word; it SHALL be a power of two from 1 to 8.
REQ-002 SHALL have parameter DEPTH, default 512, giving the words stored; DEPTH SHALL be at most 2^(ADDR_W-log2(NUM_BYTES)).
REQ-003 SHALL have parameter ADDR_W, default 11, giving the byte-address width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port req_valid, input, 1 bit: a request is presented.
REQ-007 SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-008 SHALL have port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-009 SHALL have port req_be, input, NUM_BYTES bits: per-lane byte enables.
REQ-010 SHALL have port req_addr, input, ADDR_W bits: byte address.
REQ-011 SHALL have port req_wdata, input, 8*NUM_BYTES bits: write data, with lane i at bits [8i+7:8i].
REQ-012 SHALL have port rsp_valid, output, 1 bit: a one-cycle response pulse.
REQ-013 SHALL have port rsp_rdata, output, 8*NUM_BYTES bits: read data.
REQ-014 SHALL have port rsp_err, output, 1 bit: the request's address was out of range.

Function
REQ-015 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1.
REQ-016 The word index SHALL be req_addr[ADDR_W-1:log2(NUM_BYTES)]; the low log2(NUM_BYTES) address bits SHALL be ignored.
REQ-017 Writes: on an accepted write, every lane with req_be[i]=1 SHALL be written at that edge; lanes with req_be[i]=0 SHALL be unchanged.
REQ-018 Every accepted request SHALL produce exactly one response: rsp_valid=1 for one cycle, on the cycle after acceptance.
REQ-019 There SHALL be no response backpressure, so back-to-back requests give back-to-back responses.
REQ-020 Read response: lane i of rsp_rdata SHALL hold the stored byte when req_be[i]=1 and 8'h00 otherwise.
REQ-021 Write response: rsp_rdata SHALL be all zeros.
REQ-022 A read that follows a write to the same word on the next cycle SHALL return the newly written data.
REQ-023 When word index >= DEPTH: no write SHALL occur, rsp_rdata SHALL be 0 and rsp_err SHALL be 1.
REQ-024 rsp_err SHALL be 0 for all other responses.
REQ-025 FSM states SHALL be INIT and READY.
REQ-026 req_ready SHALL be 1 only in READY; it SHALL be decoded from the state register.
REQ-027 In INIT, an init counter SHALL write all-zero to word init_cnt each cycle, counting 0..DEPTH-1.
REQ-028 INIT SHALL transition to READY on the cycle after init_cnt=DEPTH-1 is written.
REQ-029 READY SHALL be held until reset.
REQ-030 In INIT, req_valid SHALL be ignored and no response SHALL be produced.

Reset
REQ-031 While reset=1: state=INIT, init_cnt=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-032 Reset asserted mid-INIT SHALL restart initialisation from word 0.
REQ-033 Reset asserted in READY SHALL drop any pending response.
REQ-034 Memory array contents SHALL NOT be reset directly; only the INIT sweep clears them.

Configuration
REQ-035 The macro BANKED_DMEM_INIT_EN SHALL control the INIT sweep.
REQ-036 With BANKED_DMEM_INIT_EN defined: behaviour SHALL be as REQ-025 to REQ-030, with req_ready asserted DEPTH cycles after reset deasserts.
REQ-037 Without BANKED_DMEM_INIT_EN: no INIT state or counter SHALL exist, the reset state SHALL be READY, and req_ready SHALL be 1 on the first edge after reset deasserts.
REQ-038 Without BANKED_DMEM_INIT_EN, memory contents SHALL be undefined until written.

Structure
REQ-039 Package banked_dmem_pkg SHALL hold the state enum (INIT, READY) and the default parameter constants.
REQ-040 Sub-module dmem_lane SHALL be one 8-bit x DEPTH byte lane: clk, lane write enable, word index, data in, registered data out.
REQ-041 banked_dmem SHALL instantiate NUM_BYTES dmem_lane instances using a generate loop.

Verification
REQ-042 Bench configuration: NUM_BYTES=4, DEPTH=256, ADDR_W=11, with BANKED_DMEM_INIT_EN defined.
REQ-043 Init sweep: deassert reset -> req_ready=0 for exactly 256 cycles then 1; read addr 0x3FC with be=1111 -> rsp_rdata=0x00000000.
REQ-044 Full word: write 0xDEADBEEF, be=1111, addr 0x010; read addr 0x013, be=1111 next cycle -> rsp_valid the following cycle with 0xDEADBEEF.
REQ-045 Byte write: write 0x000000AA, be=0001, addr 0x010; read be=1111 -> 0xDEADBEAA; read be=0110 -> 0x00ADBE00.
REQ-046 Range error: write 0x12345678 to addr 0x400 -> rsp_err=1, rsp_rdata=0; read addr 0x000 -> unchanged, rsp_err=0.
REQ-047 Reset mid-INIT: assert reset at init cycle 100 for 2 cycles -> req_ready low for a full 256 cycles after release; a request held in INIT yields no rsp_valid.

Source files
------------

// File: rtl/banked_dmem_pkg.sv
// Shared types and default sizing for the banked data memory.
// Holds the controller state encoding and the default parameter values
// used by banked_dmem when no override is given.
package banked_dmem_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int DEF_NUM_BYTES = 4;
  localparam int DEF_DEPTH     = 512;
  localparam int DEF_ADDR_W    = 11;

endpackage

// File: rtl/dmem_lane.sv
// One 8-bit byte lane of the data memory, DEPTH entries deep.
// Ports: clk; we (lane write enable); idx (word index); din (write byte);
//        dout (byte at idx, registered: valid the cycle after idx is presented).
// Storage is deliberately not reset; the owner clears it if it needs to.
module dmem_lane #(
  parameter int DEPTH = 512,
  parameter int IW    = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] idx,
  input  logic [7:0]    din,
  output logic [7:0]    dout
);

  logic [7:0] mem [DEPTH];

  // Read returns the old contents when the same word is written at the
  // same edge; a read one cycle after a write sees the new byte.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= din;
    dout <= mem[idx];
  end

endmodule

// File: rtl/banked_dmem.sv
// Byte-lane banked data memory with valid/ready request side and a
// one-cycle response pulse on the cycle after each accepted request.
// Ports: clk, reset (async, active-high); req_valid/req_ready/req_we/req_be/
//        req_addr/req_wdata request; rsp_valid/rsp_rdata/rsp_err response.
// Build macro BANKED_DMEM_INIT_EN: when defined, reset starts an INIT sweep
// that zeroes every word before req_ready rises; when undefined the block
// is ready straight out of reset and contents are undefined until written.
module banked_dmem
  import banked_dmem_pkg::*;
#(
  parameter int NUM_BYTES = DEF_NUM_BYTES,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [NUM_BYTES-1:0]   req_be,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [8*NUM_BYTES-1:0] req_wdata,
  output logic                   rsp_valid,
  output logic [8*NUM_BYTES-1:0] rsp_rdata,
  output logic                   rsp_err
);

  localparam int OFF_W = $clog2(NUM_BYTES);
  localparam int IDX_W = ADDR_W - OFF_W;
  // Lane index only needs to span DEPTH; out-of-range words never touch a lane.
  localparam int LIW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [IDX_W-1:0]     word_idx;
  logic                 in_range;
  logic                 accept;
  logic                 wr_acc;
  logic                 sweep;
  logic [LIW-1:0]       lane_idx;
  logic [NUM_BYTES-1:0] lane_we;
  logic [NUM_BYTES-1:0] rd_mask_q;
  logic [7:0]           lane_dout [NUM_BYTES];
  state_t               state_q;

  // Byte-offset bits select nothing: the whole word is always addressed.
  logic unused_addr;
  assign unused_addr = ^req_addr;

  assign word_idx = req_addr[ADDR_W-1:OFF_W];
  assign in_range = (32'(word_idx) < DEPTH);
  assign accept   = req_valid & req_ready;
  assign wr_acc   = accept & req_we & in_range;

`ifdef BANKED_DMEM_INIT_EN
  state_t         state_d;
  logic [LIW-1:0] init_cnt_q;
  logic [LIW-1:0] init_cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Sweep one word per cycle; leave INIT once the last word has been written.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      INIT: begin
        init_cnt_d = init_cnt_q + LIW'(1);
        if (init_cnt_q == LIW'(DEPTH - 1)) state_d = READY;
      end
      READY:   state_d = READY;
      default: state_d = INIT;
    endcase
  end

  assign req_ready = (state_q == READY);
  assign sweep     = (state_q == INIT);
  assign lane_idx  = sweep ? init_cnt_q : word_idx[LIW-1:0];
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= READY;
    else       state_q <= READY;
  end

  // Held off only while reset itself is asserted.
  assign req_ready = (state_q == READY) & ~reset;
  assign sweep     = 1'b0;
  assign lane_idx  = word_idx[LIW-1:0];
`endif

  for (genvar i = 0; i < NUM_BYTES; i++) begin : g_lane
    assign lane_we[i] = sweep | (wr_acc & req_be[i]);

    dmem_lane #(
      .DEPTH (DEPTH),
      .IW    (LIW)
    ) u_lane (
      .clk  (clk),
      .we   (lane_we[i]),
      .idx  (lane_idx),
      .din  (sweep ? 8'h00 : req_wdata[8*i +: 8]),
      .dout (lane_dout[i])
    );

    // Lane data is only exposed for enabled lanes of an in-range read.
    assign rsp_rdata[8*i +: 8] = lane_dout[i] & {8{rd_mask_q[i]}};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rd_mask_q <= '0;
    end else begin
      rsp_valid <= accept;
      rsp_err   <= accept & ~in_range;
      rd_mask_q <= (accept & ~req_we & in_range) ? req_be : '0;
    end
  end

endmodule

// File: tb/tb_banked_dmem.sv
module tb_banked_dmem;

  localparam int NB    = 4;
  localparam int DEPTH = 256;
  localparam int AW    = 11;
`ifdef BANKED_DMEM_INIT_EN
  localparam int INIT_CYC = DEPTH;
`else
  localparam int INIT_CYC = 0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [NB-1:0] req_be;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;

  banked_dmem #(
    .NUM_BYTES (NB),
    .DEPTH     (DEPTH),
    .ADDR_W    (AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_be    (req_be),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic        we;
    logic [3:0]  be;
    logic [10:0] addr;
    logic [31:0] wdata;
    logic        e_vld;
    logic        e_err;
    logic [31:0] e_rdata;
  } vec_t;

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one request cycle; the response for it is sampled after the edge.
  task automatic run_vec(input vec_t v, input int n);
    req_valid = v.vld;
    req_we    = v.we;
    req_be    = v.be;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    @(posedge clk);
    #1;
    chk($sformatf("vec%0d rsp_valid", n), 32'(rsp_valid), 32'(v.e_vld));
    if (v.e_vld) begin
      chk($sformatf("vec%0d rsp_err", n), 32'(rsp_err), 32'(v.e_err));
      chk($sformatf("vec%0d rsp_rdata", n), rsp_rdata, v.e_rdata);
    end
  endtask

  // Count edges until req_ready rises, noting any response seen meanwhile.
  task automatic wait_ready(output int cyc, output logic saw_rsp);
    cyc     = 0;
    saw_rsp = 1'b0;
    while (req_ready !== 1'b1 && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (rsp_valid !== 1'b0) saw_rsp = 1'b1;
    end
  endtask

  vec_t tbl [15];
  vec_t v;
  int   cyc;
  logic saw;

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 4'hF, 11'h000, 32'h5A5A5A5A, 1'b1, 1'b0, 32'h00000000};
    tbl[1]  = '{1'b1, 1'b1, 4'hF, 11'h010, 32'hDEADBEEF, 1'b1, 1'b0, 32'h00000000};
    tbl[2]  = '{1'b1, 1'b0, 4'hF, 11'h013, 32'h00000000, 1'b1, 1'b0, 32'hDEADBEEF};
    tbl[3]  = '{1'b1, 1'b1, 4'h1, 11'h010, 32'h000000AA, 1'b1, 1'b0, 32'h00000000};
    tbl[4]  = '{1'b1, 1'b0, 4'hF, 11'h010, 32'h00000000, 1'b1, 1'b0, 32'hDEADBEAA};
    tbl[5]  = '{1'b1, 1'b0, 4'h6, 11'h010, 32'h00000000, 1'b1, 1'b0, 32'h00ADBE00};
    tbl[6]  = '{1'b1, 1'b1, 4'hF, 11'h400, 32'h12345678, 1'b1, 1'b1, 32'h00000000};
    tbl[7]  = '{1'b1, 1'b0, 4'hF, 11'h000, 32'h00000000, 1'b1, 1'b0, 32'h5A5A5A5A};
    tbl[8]  = '{1'b0, 1'b0, 4'hF, 11'h010, 32'h00000000, 1'b0, 1'b0, 32'h00000000};
    tbl[9]  = '{1'b1, 1'b1, 4'h0, 11'h010, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h00000000};
    tbl[10] = '{1'b1, 1'b0, 4'h8, 11'h011, 32'h00000000, 1'b1, 1'b0, 32'hDE000000};
    tbl[11] = '{1'b1, 1'b0, 4'hF, 11'h7FC, 32'h00000000, 1'b1, 1'b1, 32'h00000000};
    tbl[12] = '{1'b1, 1'b0, 4'h0, 11'h010, 32'h00000000, 1'b1, 1'b0, 32'h00000000};
    tbl[13] = '{1'b1, 1'b1, 4'hF, 11'h3FD, 32'hCAFEF00D, 1'b1, 1'b0, 32'h00000000};
    tbl[14] = '{1'b1, 1'b0, 4'hF, 11'h3FC, 32'h00000000, 1'b1, 1'b0, 32'hCAFEF00D};

    // Reset, with a read request held so INIT can be seen ignoring it.
    reset     = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_be    = 4'hF;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset req_ready", 32'(req_ready), 32'd0);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'd0);
    chk("reset rsp_err", 32'(rsp_err), 32'd0);

    reset = 1'b0;
    #1;
    wait_ready(cyc, saw);
    req_valid = 1'b0;
    chk("init cycles", 32'(cyc), 32'(INIT_CYC));
    chk("init no response", 32'(saw), 32'd0);

`ifdef BANKED_DMEM_INIT_EN
    v = '{1'b1, 1'b0, 4'hF, 11'h3FC, 32'h0, 1'b1, 1'b0, 32'h00000000};
    run_vec(v, 100);
`endif

    // Back-to-back table: every row is one request cycle.
    for (int i = 0; i < 15; i++) run_vec(tbl[i], i);
    req_valid = 1'b0;

    // Reset in READY drops the response already in flight.
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_be    = 4'hF;
    req_addr  = 11'h010;
    @(posedge clk);
    #1;
    chk("pending rsp_valid", 32'(rsp_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("reset drop rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset drop rsp_rdata", rsp_rdata, 32'd0);
    chk("reset drop req_ready", 32'(req_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;

`ifdef BANKED_DMEM_INIT_EN
    // Interrupt the sweep at cycle 100; it must restart from word 0.
    saw = 1'b0;
    cyc = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (rsp_valid !== 1'b0) saw = 1'b1;
      if (req_ready !== 1'b0) cyc++;
    end
    chk("mid-init ready early", 32'(cyc), 32'd0);
    chk("mid-init no response", 32'(saw), 32'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    wait_ready(cyc, saw);
    req_valid = 1'b0;
    chk("re-init cycles", 32'(cyc), 32'(DEPTH));
    chk("re-init no response", 32'(saw), 32'd0);
    v = '{1'b1, 1'b0, 4'hF, 11'h010, 32'h0, 1'b1, 1'b0, 32'h00000000};
    run_vec(v, 101);
`else
    wait_ready(cyc, saw);
    req_valid = 1'b0;
    chk("re-ready cycles", 32'(cyc), 32'd0);
    v = '{1'b1, 1'b0, 4'hF, 11'h011, 32'h0, 1'b1, 1'b0, 32'hDEADBEAA};
    run_vec(v, 101);
`endif
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("idle rsp_valid", 32'(rsp_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
